// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO multiply/divide unit.
//   Single-cycle MULT/MULTU (one busy cycle), restoring radix-2 DIV/DIVU
//   (WIDTH busy cycles), direct MTHI/MTLO writes while idle.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   op_valid, op_code    request (sampled only in IDLE): 0 NOP, 1 MTHI, 2 MTLO,
//                        3 MULT, 4 MULTU, 5 DIV, 6 DIVU, 7 reserved
//   operand_a, operand_b rs / rt values
//   cancel               flush: aborts in-flight op or drops this cycle's request
//   busy                 state != IDLE (combinational)
//   done, div_by_zero    registered one-cycle pulses after a MULT/DIV commit
//   hi_read_data, lo_read_data  architectural HI / LO
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_read_data,
    output logic [WIDTH-1:0] lo_read_data
);

    localparam logic [2:0] OP_MTHI  = 3'd1;
    localparam logic [2:0] OP_MTLO  = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_MULTU = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;
    localparam logic [2:0] OP_DIVU  = 3'd6;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dbz_q;

    // multiply operands
    logic [WIDTH-1:0] mul_a_q, mul_b_q;
    logic             mul_signed_q;

    // divide datapath: quo_q starts as the dividend magnitude and shifts the
    // quotient in from the bottom as dividend bits shift out of the top
    logic [WIDTH-1:0] dvsr_q, quo_q, rem_q;
    logic             q_neg_q, r_neg_q, dvsr_zero_q;
    logic [CNT_W-1:0] cnt_q;

    // request decode
    logic accept, do_mthi, do_mtlo, start_mul, start_div, div_signed;
    logic mul_commit, div_commit, div_step;

    assign accept     = (state_q == S_IDLE) && op_valid && !cancel;
    assign do_mthi    = accept && (op_code == OP_MTHI);
    assign do_mtlo    = accept && (op_code == OP_MTLO);
    assign start_mul  = accept && ((op_code == OP_MULT) || (op_code == OP_MULTU));
    assign start_div  = accept && ((op_code == OP_DIV)  || (op_code == OP_DIVU));
    assign div_signed = (op_code == OP_DIV);

    assign div_step   = (state_q == S_DIV) && !cancel;
    assign mul_commit = (state_q == S_MUL) && !cancel;
    assign div_commit = div_step && (cnt_q == LAST_ITER);

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_mul)      state_d = S_MUL;
                else if (start_div) state_d = S_DIV;
            end
            S_MUL:   state_d = S_IDLE;
            S_DIV: begin
                if (cancel || div_commit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // multiply: sign/zero-extend to 2*WIDTH so one unsigned multiply gives
    // the correct low 2*WIDTH bits for both MULT and MULTU
    logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;

    always_comb begin
        mul_a_ext = {{WIDTH{mul_signed_q & mul_a_q[WIDTH-1]}}, mul_a_q};
        mul_b_ext = {{WIDTH{mul_signed_q & mul_b_q[WIDTH-1]}}, mul_b_q};
        product   = mul_a_ext * mul_b_ext;
    end

    // operand magnitudes for divide start
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = div_signed && operand_a[WIDTH-1];
        b_neg = div_signed && operand_b[WIDTH-1];
        a_mag = a_neg ? (~operand_a + 1'b1) : operand_a;
        b_mag = b_neg ? (~operand_b + 1'b1) : operand_b;
    end

    // one restoring iteration; partial remainder stays below the divisor, so
    // the subtraction result always fits in WIDTH bits when it is taken
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_nx, quo_nx, quo_res, rem_res;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvsr_q});
        rem_nx  = fits ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], fits};
        // -2^(W-1) / -1 wraps back to -2^(W-1) naturally here
        quo_res = q_neg_q ? (~quo_nx + 1'b1) : quo_nx;
        rem_res = r_neg_q ? (~rem_nx + 1'b1) : rem_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            done_q       <= 1'b0;
            dbz_q        <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            dvsr_q       <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            dvsr_zero_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= mul_commit || div_commit;
            dbz_q   <= div_commit && dvsr_zero_q;

            if (do_mthi) hi_q <= operand_a;
            if (do_mtlo) lo_q <= operand_a;

            if (start_mul) begin
                mul_a_q      <= operand_a;
                mul_b_q      <= operand_b;
                mul_signed_q <= (op_code == OP_MULT);
            end

            if (mul_commit) begin
                hi_q <= product[2*WIDTH-1:WIDTH];
                lo_q <= product[WIDTH-1:0];
            end

            if (start_div) begin
                dvsr_q      <= b_mag;
                quo_q       <= a_mag;
                rem_q       <= '0;
                q_neg_q     <= a_neg ^ b_neg;
                r_neg_q     <= a_neg;
                dvsr_zero_q <= (operand_b == '0);
                cnt_q       <= '0;
            end else if (div_step) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // a zero divisor runs the full length but leaves HI/LO alone
            if (div_commit && !dvsr_zero_q) begin
                lo_q <= quo_res;
                hi_q <= rem_res;
            end
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign div_by_zero  = dbz_q;
    assign hi_read_data = hi_q;
    assign lo_read_data = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] operand_a, operand_b;
    logic        cancel;
    logic        busy, done, div_by_zero;
    logic [31:0] hi_read_data, lo_read_data;

    hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_code      (op_code),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .cancel       (cancel),
        .busy         (busy),
        .done         (done),
        .div_by_zero  (div_by_zero),
        .hi_read_data (hi_read_data),
        .lo_read_data (lo_read_data)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge; returns busy-cycle count and done/dbz pulse
    // counts observed from the accept edge until two cycles after busy drops.
    task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cyc, output int done_cnt, output int dbz_cnt);
        op_valid  = 1'b1;
        op_code   = code;
        operand_a = a;
        operand_b = b;
        @(negedge clock);
        op_valid  = 1'b0;
        op_code   = 3'd0;
        busy_cyc  = 0;
        done_cnt  = 0;
        dbz_cnt   = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            busy_cyc++;
            if (done) done_cnt++;
            if (div_by_zero) dbz_cnt++;
            @(negedge clock);
        end
        for (int i = 0; i < 2; i++) begin
            if (done) done_cnt++;
            if (div_by_zero) dbz_cnt++;
            @(negedge clock);
        end
    endtask

    typedef struct {
        logic        pre;       // preload HI and LO with pre_val first
        logic [31:0] pre_val;
        logic [2:0]  code;
        logic [31:0] a, b;
        int          exp_busy, exp_done, exp_dbz;
        logic [31:0] exp_hi, exp_lo;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int bc, dc, zc, dcount;

        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0;
        operand_a = '0; operand_b = '0; cancel = 1'b0;

        //               pre   pre_val        code  a             b             busy done dbz  hi            lo
        vecs[0]  = '{1'b0, 32'h0,        3'd1, 32'hCAFEF00D, 32'h0,        0,  0,  0, 32'hCAFEF00D, 32'h9ABCDEF0};
        vecs[1]  = '{1'b0, 32'h0,        3'd2, 32'h0BADBEEF, 32'h0,        0,  0,  0, 32'hCAFEF00D, 32'h0BADBEEF};
        vecs[2]  = '{1'b0, 32'h0,        3'd3, 32'hFFFFFFFE, 32'h3,        1,  1,  0, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[3]  = '{1'b0, 32'h0,        3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  1,  0, 32'hFFFFFFFE, 32'h00000001};
        vecs[4]  = '{1'b0, 32'h0,        3'd3, 32'h80000000, 32'h80000000, 1,  1,  0, 32'h40000000, 32'h00000000};
        vecs[5]  = '{1'b0, 32'h0,        3'd4, 32'hFFFFFFFF, 32'h5,        1,  1,  0, 32'h00000004, 32'hFFFFFFFB};
        vecs[6]  = '{1'b0, 32'h0,        3'd3, 32'hFFFFFFFF, 32'h5,        1,  1,  0, 32'hFFFFFFFF, 32'hFFFFFFFB};
        vecs[7]  = '{1'b0, 32'h0,        3'd0, 32'h1,        32'h2,        0,  0,  0, 32'hFFFFFFFF, 32'hFFFFFFFB};
        vecs[8]  = '{1'b0, 32'h0,        3'd7, 32'h1,        32'h2,        0,  0,  0, 32'hFFFFFFFF, 32'hFFFFFFFB};
        vecs[9]  = '{1'b0, 32'h0,        3'd5, 32'hFFFFFFF9, 32'h2,        32, 1,  0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[10] = '{1'b0, 32'h0,        3'd6, 32'd100,      32'd7,        32, 1,  0, 32'd2,        32'd14};
        vecs[11] = '{1'b0, 32'h0,        3'd5, 32'h80000000, 32'hFFFFFFFF, 32, 1,  0, 32'h00000000, 32'h80000000};
        vecs[12] = '{1'b0, 32'h0,        3'd5, 32'd7,        32'hFFFFFFFE, 32, 1,  0, 32'h00000001, 32'hFFFFFFFD};
        vecs[13] = '{1'b0, 32'h0,        3'd6, 32'hFFFFFFFF, 32'h10,       32, 1,  0, 32'h0000000F, 32'h0FFFFFFF};
        vecs[14] = '{1'b0, 32'h0,        3'd5, 32'hFFFFFF9C, 32'hFFFFFFF9, 32, 1,  0, 32'hFFFFFFFE, 32'h0000000E};
        vecs[15] = '{1'b1, 32'hAAAA5555, 3'd6, 32'd1234,     32'h0,        32, 1,  1, 32'hAAAA5555, 32'hAAAA5555};

        // reset state
        repeat (3) @(negedge clock);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dbz", div_by_zero, 0);
        chk("reset hi", hi_read_data, 0);
        chk("reset lo", lo_read_data, 0);
        reset = 1'b0;
        @(negedge clock);

        // back-to-back MTHI then MTLO
        dcount = 0;
        op_valid = 1'b1; op_code = 3'd1; operand_a = 32'h12345678;
        @(negedge clock);
        if (done) dcount++;
        op_code = 3'd2; operand_a = 32'h9ABCDEF0;
        @(negedge clock);
        if (done) dcount++;
        op_valid = 1'b0; op_code = 3'd0;
        @(negedge clock);
        if (done) dcount++;
        chk("mt b2b hi", hi_read_data, 32'h12345678);
        chk("mt b2b lo", lo_read_data, 32'h9ABCDEF0);
        chk("mt b2b done", dcount, 0);
        chk("mt b2b busy", busy, 0);

        // table vectors
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].pre) begin
                do_op(3'd1, vecs[i].pre_val, 32'h0, bc, dc, zc);
                do_op(3'd2, vecs[i].pre_val, 32'h0, bc, dc, zc);
            end
            do_op(vecs[i].code, vecs[i].a, vecs[i].b, bc, dc, zc);
            chk($sformatf("vec%0d busy", i), bc, vecs[i].exp_busy);
            chk($sformatf("vec%0d done", i), dc, vecs[i].exp_done);
            chk($sformatf("vec%0d dbz", i),  zc, vecs[i].exp_dbz);
            chk($sformatf("vec%0d hi", i),   hi_read_data, vecs[i].exp_hi);
            chk($sformatf("vec%0d lo", i),   lo_read_data, vecs[i].exp_lo);
        end

        // DIV cancelled in its 10th busy cycle, then MTLO 5
        do_op(3'd1, 32'h11, 32'h0, bc, dc, zc);
        do_op(3'd2, 32'h22, 32'h0, bc, dc, zc);
        dcount = 0;
        op_valid = 1'b1; op_code = 3'd5; operand_a = 32'd100; operand_b = 32'd3;
        @(negedge clock);
        op_valid = 1'b0; op_code = 3'd0;
        repeat (9) begin
            if (done) dcount++;
            @(negedge clock);
        end
        chk("cancel pre busy", busy, 1);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        chk("cancel busy", busy, 0);
        repeat (3) begin
            if (done) dcount++;
            @(negedge clock);
        end
        chk("cancel done", dcount, 0);
        chk("cancel hi", hi_read_data, 32'h11);
        chk("cancel lo", lo_read_data, 32'h22);
        do_op(3'd2, 32'd5, 32'h0, bc, dc, zc);
        chk("post-cancel lo", lo_read_data, 32'd5);
        chk("post-cancel hi", hi_read_data, 32'h11);

        // cancel in IDLE drops an MTHI request
        cancel = 1'b1; op_valid = 1'b1; op_code = 3'd1; operand_a = 32'h99;
        @(negedge clock);
        cancel = 1'b0; op_valid = 1'b0; op_code = 3'd0;
        @(negedge clock);
        chk("idle cancel hi", hi_read_data, 32'h11);

        // reset during the final DIV cycle
        dcount = 0;
        op_valid = 1'b1; op_code = 3'd5; operand_a = 32'hFFFFFFF9; operand_b = 32'd2;
        @(negedge clock);
        op_valid = 1'b0; op_code = 3'd0;
        repeat (31) begin
            if (done) dcount++;
            @(negedge clock);
        end
        chk("rst-last pre busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        if (done) dcount++;
        chk("rst-last busy", busy, 0);
        chk("rst-last hi", hi_read_data, 0);
        chk("rst-last lo", lo_read_data, 0);
        repeat (2) begin
            @(negedge clock);
            if (done) dcount++;
        end
        chk("rst-last done", dcount, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO register width (even, >=8).
REQ-002 SHALL have parameter CNT_W, default 6, meaning divide iteration counter width (2^CNT_W > WIDTH).
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port op_valid  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port op_code  input  3  0 NOP, 1 MTHI, 2 MTLO, 3 MULT, 4 MULTU, 5 DIV, 6 DIVU, 7 reserved.
REQ-007 SHALL have port operand_a  input  WIDTH  rs value (dividend, multiplicand, MTHI/MTLO data).
REQ-008 SHALL have port operand_b  input  WIDTH  rt value (divisor, multiplier).
REQ-009 SHALL have port cancel  input  1  pipeline flush; aborts any in-flight or requested operation.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE; combinational from state.
REQ-011 SHALL have port done  output  1  one-cycle pulse on the edge that commits a MULT/DIV result.
REQ-012 SHALL have port div_by_zero  output  1  one-cycle pulse, coincident with done, for a zero-divisor DIV/DIVU.
REQ-013 SHALL have port hi_read_data  output  WIDTH  architectural HI register.
REQ-014 SHALL have port lo_read_data  output  WIDTH  architectural LO register.

Function
REQ-015 SHALL implement states IDLE, MUL and DIV; no other reachable state.
REQ-016 In IDLE, with op_valid=1 and cancel=0, the op SHALL be accepted on the rising edge; op_valid is ignored in MUL/DIV.
REQ-017 MTHI SHALL write operand_a into HI on the accepting edge, stay in IDLE, leave LO unchanged, and not pulse done.
REQ-018 MTLO SHALL write operand_a into LO on the accepting edge, stay in IDLE, leave HI unchanged, and not pulse done.
REQ-019 NOP and code 7 SHALL have no effect.
REQ-020 MULT/MULTU SHALL latch operands and enter MUL on the accepting edge, then on the next edge write the 2*WIDTH-bit product (upper half to HI, lower half to LO), pulse done and return to IDLE; busy is high for exactly 1 cycle.
REQ-021 MULT SHALL treat operands as two's complement; MULTU SHALL treat them as unsigned.
REQ-022 DIV/DIVU SHALL latch operand magnitudes and sign info and enter DIV with the counter at 0 on the accepting edge.
REQ-023 DIV SHALL perform one restoring radix-2 iteration per edge; on the WIDTH-th edge in DIV it SHALL write the quotient to LO and the remainder to HI, pulse done and return to IDLE; busy is high for exactly WIDTH cycles.
REQ-024 DIV SHALL give the quotient the sign a XOR b and the remainder the sign of a, truncating toward zero; DIVU SHALL be unsigned.
REQ-025 DIV of -2^(WIDTH-1) by -1 SHALL give LO=-2^(WIDTH-1) (wrapped) and HI=0, with no flag.
REQ-026 A divisor of 0 SHALL still take WIDTH cycles, leave HI and LO unchanged, and pulse done together with div_by_zero.
REQ-027 When cancel=1 in MUL or DIV, the block SHALL return to IDLE on that edge with no HI/LO write and no done.
REQ-028 When cancel=1 in IDLE, any op_valid that cycle, including MTHI/MTLO, SHALL be dropped.
REQ-029 done and div_by_zero SHALL be registered, and SHALL be low in every cycle other than the one after a commit edge.
REQ-030 HI/LO SHALL change only on MTHI, MTLO, or a MULT/DIV commit; the new value is visible the cycle after the write edge.

Reset
REQ-031 With reset=1 at a rising edge, the block SHALL enter IDLE, clear hi_read_data and lo_read_data to 0, clear done, div_by_zero and the counter, and drop any in-flight op.
REQ-032 Reset SHALL take priority over cancel, op_valid and any in-flight operation, including reset in the final DIV cycle.

Verification (WIDTH=32)
REQ-033 Bench SHALL cover: MTHI 0x12345678, then MTLO 0x9ABCDEF0 in the next cycle -> HI=0x12345678, LO=0x9ABCDEF0, done never high.
REQ-034 Bench SHALL cover: MULT a=0xFFFFFFFE (-2), b=3 -> busy high for 1 cycle; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulses once.
REQ-035 Bench SHALL cover: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 Bench SHALL cover: DIV a=-7, b=2 -> busy high for 32 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); and DIVU 100/7 -> LO=14, HI=2.
REQ-037 Bench SHALL cover: DIVU with b=0 and HI=LO=0xAAAA5555 beforehand -> after 32 cycles done=1 and div_by_zero=1, HI/LO unchanged.
REQ-038 Bench SHALL cover: DIV with cancel in cycle 10, then MTLO 5 -> no done, HI/LO as before the DIV, then LO=5; separately, reset in the final DIV cycle -> HI=LO=0, busy=0, no done.
